// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 key decoder
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_event_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_BREAK) || (b == PS2_EXT);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - pin conditioning, 11-bit frame FSM and inter-bit timeout
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err,
    output logic       abort
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   s_clk;
    logic                   s_data;
    logic [FW-1:0]          flt_cnt;
    logic                   flt_clk;
    logic                   strobe;
    logic                   sample;

    frame_state_t  state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] to_cnt;

    assign s_clk  = clk_sync[SYNC_STAGES-1];
    assign s_data = data_sync[SYNC_STAGES-1];

    // Sync chains idle high so leaving reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flt_clk <= 1'b1;
            flt_cnt <= '0;
            strobe  <= 1'b0;
            sample  <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (s_clk == flt_clk) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_MAX) begin
                flt_clk <= s_clk;
                flt_cnt <= '0;
                strobe  <= ~s_clk;
                sample  <= s_data;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
            abort      <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            err        <= 1'b0;
            abort      <= 1'b0;

            if (state == ST_IDLE || strobe) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (state != ST_IDLE && to_cnt == TO_MAX && !strobe) begin
                state <= ST_IDLE;
                err   <= 1'b1;
                abort <= 1'b1;
            end else if (strobe) begin
                case (state)
                    ST_IDLE: begin
                        if (!sample) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg <= {sample, shreg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        par   <= sample;
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (sample && (^{shreg, par})) begin
                            rx_byte    <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            err   <= 1'b1;
                            abort <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 receiver top: prefix decoder and first-word fall-through event FIFO
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_break,
    output logic       evt_ext,
    output logic       frame_err,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       rx_abort;

    logic       ext_pend;
    logic       brk_pend;

    ps2_event_t mem [FIFO_DEPTH];
    ps2_event_t head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        push_req;
    logic        push_ok;
    logic        pop;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .err        (frame_err),
        .abort      (rx_abort)
    );

    // Wrap bit differs with equal index bits means full.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_req = byte_valid && !is_prefix(rx_byte);
    assign pop      = evt_valid && evt_ready;
    assign push_ok  = push_req && (!full || pop);

    assign head      = mem[rd_ptr[AW-1:0]];
    assign evt_valid = !empty;
    assign evt_code  = evt_valid ? head.code : 8'h00;
    assign evt_break = evt_valid & head.brk;
    assign evt_ext   = evt_valid & head.ext;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= '{code: rx_byte, brk: brk_pend, ext: ext_pend};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end else begin
            overflow <= push_req && full && !pop;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            // A corrupted or stalled frame may have been the byte a prefix applied to.
            if (rx_abort) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end else if (byte_valid) begin
                if (rx_byte == PS2_EXT) begin
                    ext_pend <= 1'b1;
                end else if (rx_byte == PS2_BREAK) begin
                    brk_pend <= 1'b1;
                end else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int TOUT = 400;
    localparam int DEPTH = 4;
    localparam int HALF = 20;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    typedef struct {
        logic [7:0] b;
        logic       flip;
        logic       stop;
        logic       exp_ev;
        logic [7:0] code;
        logic       brk;
        logic       ext;
        logic       exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_break;
    logic       evt_ext;
    logic       frame_err;
    logic       overflow;

    logic ready_fix = 1'b1;
    logic rnd_mode = 1'b0;
    logic rnd_bit = 1'b0;
    assign evt_ready = rnd_mode ? rnd_bit : ready_fix;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    int ovf_cnt = 0;
    ev_t got_q[$];

    ps2_key_decoder #(
        .SYNC_STAGES    (SYNC),
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TOUT),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_break (evt_break),
        .evt_ext   (evt_ext),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (evt_valid && evt_ready) got_q.push_back('{evt_code, evt_break, evt_ext});
            if (frame_err) err_cnt++;
            if (overflow) ovf_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        tick(1);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b, input logic flip, input logic stop);
        return {stop, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop);
        send_bits(frame_of(b, flip, stop), 11);
        tick(HALF);
        ps2_data = 1'b1;
    endtask

    task automatic expect_one(input string tag, input int n0, input logic [7:0] code,
                              input logic brk, input logic ext);
        check($sformatf("%s count", tag), got_q.size() - n0, 1);
        if (got_q.size() > n0) begin
            check($sformatf("%s code", tag), got_q[n0].code, code);
            check($sformatf("%s brk", tag), got_q[n0].brk, brk);
            check($sformatf("%s ext", tag), got_q[n0].ext, ext);
        end
    endtask

    vec_t vt[15];
    ev_t  exp_q[$];

    initial begin
        int e0, n0, o0, exp_errs;
        logic m_ext, m_brk;
        logic [7:0] ovf_codes[5];

        vt[0]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{8'h75, 1'b0, 1'b1, 1'b1, 8'h75, 1'b1, 1'b1, 1'b0};
        vt[4]  = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{8'h6B, 1'b0, 1'b1, 1'b1, 8'h6B, 1'b0, 1'b1, 1'b0};
        vt[10] = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[11] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vt[12] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0};
        vt[13] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[14] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};

        tick(5);
        check("reset evt_valid", evt_valid, 0);
        check("reset evt_code", evt_code, 0);
        check("reset evt_break", evt_break, 0);
        check("reset evt_ext", evt_ext, 0);
        check("reset frame_err", frame_err, 0);
        check("reset overflow", overflow, 0);
        rst = 1'b0;
        tick(20);
        check("post-reset evt_valid", evt_valid, 0);
        check("post-reset err", err_cnt, 0);

        for (int i = 0; i < 15; i++) begin
            e0 = err_cnt;
            n0 = got_q.size();
            send_frame(vt[i].b, vt[i].flip, vt[i].stop);
            tick(10);
            check($sformatf("vec%0d err", i), err_cnt - e0, int'(vt[i].exp_err));
            if (vt[i].exp_ev) expect_one($sformatf("vec%0d", i), n0, vt[i].code, vt[i].brk, vt[i].ext);
            else check($sformatf("vec%0d no event", i), got_q.size() - n0, 0);
        end

        // Timeout after 5 data bits; the pending F0 must not leak into the next key.
        send_frame(8'hF0, 1'b0, 1'b1);
        e0 = err_cnt;
        n0 = got_q.size();
        send_bits(frame_of(8'h1C, 1'b0, 1'b1), 6);
        tick(TOUT + 50);
        check("timeout err", err_cnt - e0, 1);
        check("timeout no event", got_q.size() - n0, 0);
        send_frame(8'h1C, 1'b0, 1'b1);
        tick(10);
        expect_one("after timeout", n0, 8'h1C, 1'b0, 1'b0);

        // Two-cycle low glitch on ps2_clk while data is low must not start a frame.
        e0 = err_cnt;
        n0 = got_q.size();
        ps2_data = 1'b0;
        tick(4);
        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(TOUT + 50);
        ps2_data = 1'b1;
        check("glitch err", err_cnt - e0, 0);
        send_frame(8'h1C, 1'b0, 1'b1);
        tick(10);
        check("glitch then frame err", err_cnt - e0, 0);
        expect_one("after glitch", n0, 8'h1C, 1'b0, 1'b0);

        // Reset in the middle of a frame.
        e0 = err_cnt;
        n0 = got_q.size();
        send_bits(frame_of(8'h1C, 1'b0, 1'b1), 4);
        rst = 1'b1;
        ps2_data = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(TOUT + 50);
        check("mid-frame reset err", err_cnt - e0, 0);
        check("mid-frame reset evt_valid", evt_valid, 0);
        send_frame(8'h1C, 1'b0, 1'b1);
        tick(10);
        expect_one("after reset", n0, 8'h1C, 1'b0, 1'b0);

        // Overflow: DEPTH+1 keys with the consumer stalled.
        ovf_codes[0] = 8'h16; ovf_codes[1] = 8'h1E; ovf_codes[2] = 8'h26;
        ovf_codes[3] = 8'h25; ovf_codes[4] = 8'h2E;
        ready_fix = 1'b0;
        o0 = ovf_cnt;
        n0 = got_q.size();
        for (int i = 0; i < 4; i++) send_frame(ovf_codes[i], 1'b0, 1'b1);
        tick(10);
        check("ovf before 5th", ovf_cnt - o0, 0);
        send_frame(ovf_codes[4], 1'b0, 1'b1);
        tick(10);
        check("ovf on 5th", ovf_cnt - o0, 1);
        check("ovf head valid", evt_valid, 1);
        check("ovf head code", evt_code, 8'h16);
        check("ovf nothing popped", got_q.size() - n0, 0);
        ready_fix = 1'b1;
        tick(10);
        check("ovf drained count", got_q.size() - n0, 4);
        for (int i = 0; i < 4; i++) begin
            if (got_q.size() > n0 + i)
                check($sformatf("ovf pop%0d code", i), got_q[n0 + i].code, ovf_codes[i]);
        end
        check("ovf drained valid", evt_valid, 0);

        // Random frames against a prefix-rule model with a randomly stalling consumer.
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_errs = 0;
        e0 = err_cnt;
        n0 = got_q.size();
        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            logic bad;
            int r;
            r = $urandom_range(0, 9);
            b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 7) == 0);
            send_frame(b, bad, 1'b1);
            if (bad) begin
                exp_errs++;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end else if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else begin
                exp_q.push_back('{b, m_brk, m_ext});
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
        rnd_mode = 1'b0;
        ready_fix = 1'b1;
        tick(20);
        check("random err count", err_cnt - e0, exp_errs);
        check("random event count", got_q.size() - n0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (got_q.size() > n0 + i)
                check($sformatf("random ev%0d", i), got_q[n0 + i], exp_q[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 keyboard receiver that turns raw `ps2_clk`/`ps2_data` pin activity into complete key events. Each event carries the scan code, a make/break flag and an extended (E0) flag. The block validates every 11-bit frame (start, 8 data LSB-first, odd parity, stop), filters clock glitches and aborts stalled frames with a timeout. Events are buffered in a small FIFO with a valid/ready output, and the block sits between the keyboard pins and the game-control logic.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth on both pins (≥2).
- `FILTER_LEN`, 4: consecutive equal samples needed before the filtered `ps2_clk` changes (≥1).
- `TIMEOUT_CYCLES`, 50000: max `clk` cycles between falling edges inside a frame (1 ms at 50 MHz).
- `FIFO_DEPTH`, 4: event FIFO entries (power of 2, ≥2).

Ports:
- `clk`  in  1  system clock; the block's single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `ps2_clk`  in  1  raw keyboard clock pin, asynchronous.
- `ps2_data`  in  1  raw keyboard data pin, asynchronous.
- `evt_valid`  out  1  FIFO non-empty; head event presented.
- `evt_ready`  in  1  consumer accepts the head event when `evt_valid & evt_ready`.
- `evt_code`  out  8  scan code of the head event.
- `evt_break`  out  1  head event is a release (preceded by F0).
- `evt_ext`  out  1  head event is extended (preceded by E0).
- `frame_err`  out  1  1-cycle pulse on a parity, stop, start or timeout error.
- `overflow`  out  1  1-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- **Input conditioning:** sync registers reset to 1 (idle line level), so reset produces no spurious edge. The filtered clock updates only after `FILTER_LEN` identical synced samples. A falling edge of the filtered clock is one sample strobe.
- **Frame FSM** (states IDLE, DATA, PARITY, STOP):
  - IDLE: on strobe, data=0 → DATA (bit count 0). Data=1 → `frame_err` pulse, stay IDLE.
  - DATA: shift data in LSB-first. After the 8th bit → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: the frame is good if stop=1 and the total number of ones in data plus parity is odd. A good frame is handed to the prefix decoder. Otherwise `frame_err` pulses, the byte is discarded and both prefix flags clear. Always → IDLE.
- **Timeout:** in DATA, PARITY or STOP, the cycle counter resets on every strobe. Reaching `TIMEOUT_CYCLES` forces IDLE, pulses `frame_err` and clears the prefix flags.
- **Prefix decoder:**
  - 0xE0 sets `ext_pend`.
  - 0xF0 sets `brk_pend`.
  - Any other byte pushes {code, `brk_pend`, `ext_pend`} into the FIFO and clears both flags.
  - Prefix bytes never produce events. Repeated prefixes are idempotent.
- **FIFO:** first-word fall-through.
  - Pop on `evt_valid & evt_ready`.
  - Push while full with no pop in the same cycle: the event is dropped and `overflow` pulses.
  - Push and pop in the same cycle while full: both are accepted and the count is unchanged.
  - Push and pop in the same cycle while empty: the push is stored and `evt_valid` rises next cycle.
- **Reset values:** all outputs 0, FIFO empty, FSM IDLE, prefix flags 0, timeout counter 0.
- **Reset mid-frame:** the partial frame is discarded and no error is reported.

## Timing
- Pin transition to strobe: `SYNC_STAGES + FILTER_LEN + 1` cycles.
- Stop-bit strobe at cycle N:
  - `frame_err` (if any) high in N+1.
  - Decoder result registered at N+1, FIFO write at the end of N+1.
  - `evt_valid` high from N+2 when the FIFO was empty.
- `evt_code`, `evt_break` and `evt_ext` are stable while `evt_valid=1` and `evt_ready=0`.
- After a pop, the next entry appears the following cycle. `evt_valid` drops the following cycle if the FIFO becomes empty.
- The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide and saturates. The FIFO uses `$clog2(FIFO_DEPTH)+1`-bit pointers (wrap bit distinguishes full from empty).

## Structure
- `ps2_pkg` holds:
  - The frame FSM state enum.
  - Constants `PS2_BREAK=8'hF0` and `PS2_EXT=8'hE0`.
  - The packed event struct {code[7:0], brk, ext}.
- One sub-module, `ps2_frame_rx`: conditioning, frame FSM and timeout. It outputs byte + `byte_valid` + `err`.
- Prefix decoder and FIFO stay in the top.

## Test plan
- Frame 0x1C (parity 0) with `evt_ready=1` → one event: code 0x1C, break 0, ext 0.
- Sequence E0, F0, 75 → exactly one event: code 0x75, break 1, ext 1.
- Frame 0x1C with parity bit 1 → `frame_err` pulse, no event. The next frame F0,1C yields code 0x1C with break 1, showing the F0 prefix still applies after an error.
- Stop transmitting after 5 data bits for > `TIMEOUT_CYCLES` → `frame_err` pulse. The next full 0x1C frame decodes correctly.
- `evt_ready=0`, send `FIFO_DEPTH+1` make codes 0x16, 0x1E, 0x26, 0x25, 0x2E → `overflow` pulses once on the 5th. Raising `evt_ready` pops 0x16..0x25 in order.
- 2-cycle glitch on `ps2_clk` with `FILTER_LEN=4` → no strobe, no bit shifted.
